fir_ctrl: RTL and testbench
===========================

FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 Parameter DIV, default 4: clock cycles per sample slot; legal range 1..255.
REQ-002 Parameter TAPS, default 8: frame bits per run, and the number of fir_sample pulses per run.
REQ-003 Parameter LAT, default 1: clock cycles from the last fir_sample pulse to fir_data being valid; minimum 1.
REQ-004 Parameter DW, default 32: filter output width.
REQ-005 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port start, input, 1: request a filter run; sampled only in IDLE.
REQ-008 Port frame, input, TAPS: barcode bit frame; latched on the accepted start.
REQ-009 Port fir_sample, output, 1: one-cycle strobe to the FIR that shifts in fir_signal.
REQ-010 Port fir_signal, output, 1: current frame bit presented to the FIR.
REQ-011 Port fir_data, input, DW: FIR accumulated output.
REQ-012 Port result, output, DW: captured filter result.
REQ-013 Port result_valid, output, 1: result is available for the downstream consumer.
REQ-014 Port result_ready, input, 1: downstream consumer accepts result.
REQ-015 Port busy, output, 1: high whenever the state is not IDLE.
REQ-016 Port done, output, 1: one-cycle pulse after result is consumed.

Function
REQ-017 The FSM shall have exactly four states, IDLE, SHIFT, WAIT and OUT, all registered.
REQ-018 IDLE with start=1 at a clock edge: latch frame, clear the bit index and divider, and go to SHIFT.
REQ-019 SHIFT: fir_sample is high in the first SHIFT cycle, then every DIV cycles, for exactly TAPS pulses total.
REQ-020 fir_signal = latched frame[bit index], sent LSB first; the value is held for the whole DIV-cycle slot and is stable while fir_sample is high.
REQ-021 The bit index shall increment at the end of each slot.
REQ-022 After the slot holding pulse TAPS ends, the FSM goes to WAIT; with DIV=1 it goes to WAIT on the cycle after the last pulse.
REQ-023 WAIT: count LAT cycles from the last pulse.
REQ-024 At the edge ending the LAT-th WAIT cycle, result <= fir_data and the FSM goes to OUT.
REQ-025 OUT: result_valid=1 and result is held stable until result_ready=1 at a clock edge.
REQ-026 On the accepting edge, the FSM goes to IDLE, result_valid goes to 0, and done=1 for exactly the next cycle.
REQ-027 A start asserted in any state other than IDLE is ignored and not queued.
REQ-028 A start in the same cycle as the OUT handshake is ignored.
REQ-029 Changes on frame while busy shall have no effect on the current run.
REQ-030 fir_sample shall never be asserted outside SHIFT.
REQ-031 The divider and bit-index counters shall be sized $clog2 of their limits and shall not wrap mid-run.
REQ-032 result is kept after the handshake; it is overwritten only by the next capture.

Reset
REQ-033 When reset=1, asynchronously force: state IDLE, fir_sample=0, fir_signal=0, result=0, result_valid=0, busy=0, done=0, and all counters=0.
REQ-034 A reset during SHIFT, WAIT or OUT aborts the run; no done pulse is produced and no partial result is kept.
REQ-035 The first start after reset release begins at bit 0.

Structure
REQ-036 Package fir_ctrl_pkg shall hold the state enum type and the default values of DIV, TAPS, LAT and DW.
REQ-037 Slot timing shall live in one sub-module, sample_tick: it takes an enable, holds a DIV counter, and emits a tick strobe on its first enabled cycle and every DIV cycles after.
REQ-038 The FIR instance sits outside this block: fir_sample drives the FIR sample input, fir_signal drives its signal input, and the FIR output drives fir_data.

Verification
REQ-039 Nominal run: DIV=4, TAPS=8, LAT=1, frame=8'b10010110, start pulsed once.
- fir_signal sequence: 0,1,1,0,1,0,0,1.
- fir_sample high at cycles 1,5,9,...,29 after the start edge.
- Model FIR returns 286: result=286, result_valid rises at cycle 33, with result_ready=1 done pulses one cycle later.
REQ-040 Backpressure: hold result_ready=0 for 10 cycles in OUT -> result_valid stays 1, result stays 286, and done stays 0 until ready.
REQ-041 Start while busy: pulse start with frame=8'hFF during SHIFT -> ignored; the pulse count stays 8 and the bit sequence is unchanged.
REQ-042 Reset mid-run: assert reset after the 3rd pulse -> all outputs go to 0 immediately.
- Next start with frame=8'h01 gives fir_signal 1 then seven 0s.
REQ-043 DIV=1 and LAT=3: fir_sample high for 8 consecutive cycles, and the capture happens 3 cycles after the last pulse.
REQ-044 Bench checks on every cycle:
- fir_sample is never high outside SHIFT.
- busy equals (state != IDLE).

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: state encoding and default parameters shared by the FIR controller files
package fir_ctrl_pkg;
  localparam int DIV_DEF = 4;
  localparam int TAPS_DEF = 8;
  localparam int LAT_DEF = 1;
  localparam int DW_DEF = 32;
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT, OUT} state_t;
endpackage

// File: rtl/fir_ctrl_sample_tick.sv
// sample_tick: slot divider; tick on the first enabled cycle and every DIV cycles after
module sample_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick,
  output logic last
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = en && cnt == '0;
  assign last = en && cnt == CW'(DIV - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (en && !last) ? cnt + CW'(1) : '0;
endmodule

// File: rtl/fir_ctrl.sv
// fir_ctrl: shifts a latched frame into an external FIR, waits its latency, then hands the result downstream
module fir_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int DIV = DIV_DEF,
  parameter int TAPS = TAPS_DEF,
  parameter int LAT = LAT_DEF,
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [TAPS-1:0] frame,
  output logic            fir_sample,
  output logic            fir_signal,
  input  logic [DW-1:0]   fir_data,
  output logic [DW-1:0]   result,
  output logic            result_valid,
  input  logic            result_ready,
  output logic            busy,
  output logic            done
);
  localparam int IW = TAPS > 1 ? $clog2(TAPS) : 1;
  localparam int LW = LAT > 1 ? $clog2(LAT) : 1;
  state_t state, next;
  logic [TAPS-1:0] frm;
  logic [IW-1:0] idx;
  logic [LW-1:0] wcnt;
  logic tick, last, last_bit, lat_done, accept;
  sample_tick #(.DIV(DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .en(state == SHIFT),
    .tick(tick),
    .last(last)
  );
  assign last_bit = idx == IW'(TAPS - 1);
  assign lat_done = wcnt == LW'(LAT - 1);
  assign accept = state == OUT && result_ready;
  assign fir_sample = tick;
  assign fir_signal = state == SHIFT && frm[idx];
  assign busy = state != IDLE;
  assign result_valid = state == OUT;
  always_comb begin
    next = state;
    unique case (state)
      IDLE:  next = start ? SHIFT : IDLE;
      SHIFT: next = (last && last_bit) ? WAIT : SHIFT;
      WAIT:  next = lat_done ? OUT : WAIT;
      OUT:   next = result_ready ? IDLE : OUT;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  // frame is only latched on an accepted start, so changes while busy are invisible
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      frm <= '0;
      idx <= '0;
      wcnt <= '0;
      result <= '0;
      done <= 1'b0;
    end else begin
      done <= accept;
      if (state == IDLE && start) begin
        frm <= frame;
        idx <= '0;
      end else if (state == SHIFT && last) idx <= last_bit ? '0 : idx + IW'(1);
      wcnt <= (state == WAIT && !lat_done) ? wcnt + LW'(1) : '0;
      if (state == WAIT && lat_done) result <= fir_data;
    end
endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: two controller configurations checked every cycle against a cycle-count reference model
module tb_fir_ctrl;
  localparam int TAPS = 8;
  logic clk = 0, reset = 1;
  logic start_a = 0, start_b = 0, ready_a = 1, ready_b = 1;
  logic [7:0] frame_a = 0, frame_b = 0;
  logic [31:0] fir_data = 0;
  logic [1:0] o_samp, o_sig, o_busy, o_valid, o_done;
  logic [31:0] o_res[2];
  int vectors = 0, errs = 0, k = 0, k0 = 0, rec = 0, vrise = -1, drise = -1;
  int div_p[2] = '{4, 1};
  int lat_p[2] = '{1, 3};
  bit m_act[2], m_done[2], pv, hold_fd = 0;
  int m_c[2];
  logic [7:0] m_frm[2];
  logic [31:0] m_res[2];
  int pk[$];
  logic bits[$];
  always #5 clk = ~clk;
  fir_ctrl #(.DIV(4), .TAPS(8), .LAT(1), .DW(32)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .frame(frame_a),
    .fir_sample(o_samp[0]), .fir_signal(o_sig[0]), .fir_data(fir_data),
    .result(o_res[0]), .result_valid(o_valid[0]), .result_ready(ready_a),
    .busy(o_busy[0]), .done(o_done[0])
  );
  fir_ctrl #(.DIV(1), .TAPS(8), .LAT(3), .DW(32)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .frame(frame_b),
    .fir_sample(o_samp[1]), .fir_signal(o_sig[1]), .fir_data(fir_data),
    .result(o_res[1]), .result_valid(o_valid[1]), .result_ready(ready_b),
    .busy(o_busy[1]), .done(o_done[1])
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_done[i] = 0; m_c[i] = 0; m_res[i] = 0; m_frm[i] = 0;
    end
  endtask
  // run i: cycle c=0 is the first cycle after the start edge; TAPS*DIV shift cycles, LAT wait cycles, then OUT
  task automatic model_step(input int i, input logic s, input logic r, input logic [7:0] f, input logic [31:0] fd);
    int tl;
    tl = TAPS * div_p[i] + lat_p[i];
    m_done[i] = 0;
    if (m_act[i]) begin
      if (m_c[i] == tl - 1) m_res[i] = fd;
      if (m_c[i] >= tl && r) begin
        m_act[i] = 0;
        m_done[i] = 1;
      end else m_c[i]++;
    end else if (s) begin
      m_act[i] = 1; m_c[i] = 0; m_frm[i] = f;
    end
  endtask
  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int td;
      bit sh;
      td = TAPS * div_p[i];
      sh = m_act[i] && m_c[i] < td;
      chk($sformatf("u%0d_sample", i), 32'(o_samp[i]), 32'(sh && m_c[i] % div_p[i] == 0));
      chk($sformatf("u%0d_signal", i), 32'(o_sig[i]), 32'(sh && m_frm[i][m_c[i] / div_p[i]]));
      chk($sformatf("u%0d_busy", i), 32'(o_busy[i]), 32'(m_act[i]));
      chk($sformatf("u%0d_valid", i), 32'(o_valid[i]), 32'(m_act[i] && m_c[i] >= td + lat_p[i]));
      chk($sformatf("u%0d_done", i), 32'(o_done[i]), 32'(m_done[i]));
      chk($sformatf("u%0d_result", i), o_res[i], m_res[i]);
    end
  endtask
  task automatic begin_rec(input int i);
    rec = i; k0 = k; vrise = -1; drise = -1; pv = 0;
    pk.delete(); bits.delete();
  endtask
  task automatic tick();
    logic [1:0] st, rd;
    logic [7:0] fa, fb;
    logic [31:0] fd;
    logic rs;
    st = {start_b, start_a}; rd = {ready_b, ready_a};
    fa = frame_a; fb = frame_b; fd = fir_data; rs = reset;
    @(posedge clk);
    #1;
    k++;
    if (rs) model_clear();
    else begin
      model_step(0, st[0], rd[0], fa, fd);
      model_step(1, st[1], rd[1], fb, fd);
    end
    check_all();
    if (o_samp[rec]) begin
      pk.push_back(k - k0);
      bits.push_back(o_sig[rec]);
    end
    if (o_valid[rec] && !pv) vrise = k - k0 - 1;
    if (o_done[rec] && drise < 0) drise = k - k0;
    pv = o_valid[rec];
    fir_data = hold_fd ? 32'd286 : $urandom;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  function automatic logic [7:0] bits_vec();
    logic [7:0] v = 0;
    for (int i = 0; i < bits.size() && i < 8; i++) v[i] = bits[i];
    return v;
  endfunction
  initial begin
    model_clear();
    #1;
    check_all();
    ticks(2);
    reset = 0;
    ticks(2);
    // nominal run on the DIV=4, LAT=1 instance
    hold_fd = 1;
    fir_data = 286;
    begin_rec(0);
    frame_a = 8'b10010110;
    start_a = 1;
    tick();
    start_a = 0;
    ticks(40);
    chk("nom_pulses", pk.size(), 8);
    for (int j = 0; j < pk.size() && j < 8; j++) chk($sformatf("nom_pulse%0d", j), pk[j], 1 + 4 * j);
    chk("nom_bits", bits_vec(), 8'b10010110);
    chk("nom_result", o_res[0], 286);
    chk("nom_valid_edge", vrise, 33);
    chk("nom_done_cycle", drise, 35);
    // backpressure: OUT held for 10 cycles
    ready_a = 0;
    begin_rec(0);
    frame_a = 8'h5A;
    start_a = 1;
    tick();
    start_a = 0;
    ticks(34 + 10);
    chk("bp_valid", o_valid[0], 1);
    chk("bp_result", o_res[0], 286);
    chk("bp_done", drise, -1);
    ready_a = 1;
    ticks(3);
    chk("bp_done_after", drise, 46);
    hold_fd = 0;
    // start while busy is ignored, frame changes have no effect
    ready_a = 0;
    begin_rec(0);
    frame_a = 8'b10010110;
    start_a = 1;
    tick();
    start_a = 0;
    frame_a = 8'h3C;
    ticks(10);
    start_a = 1;
    frame_a = 8'hFF;
    tick();
    start_a = 0;
    frame_a = 8'h00;
    ticks(30);
    chk("busy_start_pulses", pk.size(), 8);
    chk("busy_start_bits", bits_vec(), 8'b10010110);
    start_a = 1;
    ready_a = 1;
    tick();
    start_a = 0;
    chk("hs_start_busy", o_busy[0], 0);
    tick();
    chk("hs_start_busy2", o_busy[0], 0);
    // asynchronous reset after the 3rd pulse
    begin_rec(0);
    frame_a = $urandom;
    start_a = 1;
    tick();
    start_a = 0;
    for (int n = 0; n < 40 && pk.size() < 3; n++) tick();
    chk("rst_reach3", pk.size(), 3);
    #2 reset = 1;
    #1;
    model_clear();
    check_all();
    chk("rst_busy", o_busy[0], 0);
    chk("rst_sample", o_samp[0], 0);
    tick();
    reset = 0;
    ticks(2);
    begin_rec(0);
    frame_a = 8'h01;
    start_a = 1;
    tick();
    start_a = 0;
    ticks(36);
    chk("rst_next_pulses", pk.size(), 8);
    chk("rst_next_bits", bits_vec(), 8'h01);
    // DIV=1, LAT=3 instance
    begin_rec(1);
    frame_b = $urandom;
    start_b = 1;
    tick();
    start_b = 0;
    ticks(16);
    chk("d1_pulses", pk.size(), 8);
    for (int j = 0; j < pk.size() && j < 8; j++) chk($sformatf("d1_pulse%0d", j), pk[j], 1 + j);
    chk("d1_bits", bits_vec(), frame_b);
    chk("d1_capture_edge", vrise, 11);
    // random traffic on both instances
    for (int n = 0; n < 400; n++) begin
      start_a = $urandom_range(0, 5) == 0;
      start_b = $urandom_range(0, 3) == 0;
      frame_a = $urandom;
      frame_b = $urandom;
      ready_a = $urandom_range(0, 1);
      ready_b = $urandom_range(0, 2) != 0;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
